dot_prod_seq: RTL

//  Sequencer for dot_prod_pip in the CAF datapath. On start, streams cfg_length sample pairs from the x and y

---
 rtl/dot_prod_pkg.sv | 22 ++
 rtl/dot_prod_seq_addr_gen.sv | 62 ++++++
 rtl/dot_prod_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dot_prod_pkg.sv
// Shared widths, depths and FSM state encodings for the dot-product sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dot_prod_pkg;

  localparam int DEF_XI_BITS    = 16;
  localparam int DEF_XQ_BITS    = 16;
  localparam int DEF_YI_BITS    = 16;
  localparam int DEF_YQ_BITS    = 16;
  localparam int DEF_SUM_I_SIZE = 40;
  localparam int DEF_SUM_Q_SIZE = 40;
  localparam int DEF_BUF_DEPTH  = 256;
  localparam int DEF_TIMEOUT    = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FETCH  = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_RESULT = 2'd3;

endpackage

// File: rtl/dot_prod_seq_addr_gen.sv
// Read-address generator: x from 0, y from shift (wrapping), plus a 2-stage valid delay line.
// Latency: rd_en 1 cycle after launch; beat_vld trails rd_en by 2 cycles.
// Backpressure: none; once launched it issues len contiguous reads.
module dot_prod_seq_addr_gen #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 launch,
  input  logic [ADDR_BITS:0]   len,
  input  logic [ADDR_BITS-1:0] shift,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] x_addr,
  output logic [ADDR_BITS-1:0] y_addr,
  output logic                 last_rd,
  output logic                 dat_vld,
  output logic                 beat_vld
);

  logic [ADDR_BITS:0] remain;

  // The final read is the one issued with a single read left to go.
  assign last_rd = rd_en && (remain == (ADDR_BITS+1)'(1));

  // Address counters: y wraps through natural ADDR_BITS overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en  <= 1'b0;
      x_addr <= '0;
      y_addr <= '0;
      remain <= '0;
    end else if (launch) begin
      rd_en  <= 1'b1;
      x_addr <= '0;
      y_addr <= shift;
      remain <= len;
    end else if (rd_en) begin
      if (last_rd) begin
        rd_en  <= 1'b0;
        x_addr <= '0;
        y_addr <= '0;
        remain <= '0;
      end else begin
        x_addr <= x_addr + ADDR_BITS'(1);
        y_addr <= y_addr + ADDR_BITS'(1);
        remain <= remain - (ADDR_BITS+1)'(1);
      end
    end
  end

  // Delay line: stage 1 marks buffer data valid, stage 2 marks the registered beat valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_vld  <= 1'b0;
      beat_vld <= 1'b0;
    end else begin
      dat_vld  <= rd_en;
      beat_vld <= dat_vld;
    end
  end

endmodule

// File: rtl/dot_prod_seq.sv
// Sequencer: streams one lag of x/y sample pairs into dot_prod_pip and returns the accumulated product.
// Latency: first beat 3 cycles after start; result whenever the pipeline answers (bounded by TIMEOUT).
// Backpressure: no x/y backpressure; result held on res_valid until res_ready.
module dot_prod_seq
  import dot_prod_pkg::*;
#(
  parameter int XI_BITS    = DEF_XI_BITS,
  parameter int XQ_BITS    = DEF_XQ_BITS,
  parameter int YI_BITS    = DEF_YI_BITS,
  parameter int YQ_BITS    = DEF_YQ_BITS,
  parameter int SUM_I_SIZE = DEF_SUM_I_SIZE,
  parameter int SUM_Q_SIZE = DEF_SUM_Q_SIZE,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  localparam int ADDR_BITS = $clog2(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS:0]    cfg_length,
  input  logic [ADDR_BITS-1:0]  cfg_shift,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  x_rd_en,
  output logic [ADDR_BITS-1:0]  x_rd_addr,
  input  logic [XI_BITS-1:0]    x_rd_i,
  input  logic [XQ_BITS-1:0]    x_rd_q,
  output logic                  y_rd_en,
  output logic [ADDR_BITS-1:0]  y_rd_addr,
  input  logic [YI_BITS-1:0]    y_rd_i,
  input  logic [YQ_BITS-1:0]    y_rd_q,
  output logic                  m_axis_x_tvalid,
  output logic [XI_BITS-1:0]    xi,
  output logic [XQ_BITS-1:0]    xq,
  output logic                  m_axis_y_tvalid,
  output logic [YI_BITS-1:0]    yi,
  output logic [YQ_BITS-1:0]    yq,
  output logic                  m_axis_product_tready,
  input  logic                  s_axis_product_tvalid,
  input  logic [SUM_I_SIZE-1:0] i,
  input  logic [SUM_Q_SIZE-1:0] q,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SUM_I_SIZE-1:0] res_i,
  output logic [SUM_Q_SIZE-1:0] res_q,
  output logic [ADDR_BITS-1:0]  res_shift
);

  localparam int WD_BITS = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [ADDR_BITS:0]   len_sat;
  logic [ADDR_BITS-1:0] shift_q;
  logic [WD_BITS-1:0]   wd_cnt;
  logic                 wd_expired;
  logic                 start_ok;
  logic                 launch;
  logic                 capture;
  logic                 ag_rd_en;
  logic                 ag_last;
  logic                 ag_dat_vld;
  logic                 ag_beat_vld;

  // Requests longer than the buffer are clamped to one full pass over it.
  assign len_sat = (cfg_length > (ADDR_BITS+1)'(BUF_DEPTH)) ? (ADDR_BITS+1)'(BUF_DEPTH) : cfg_length;

  assign start_ok   = (state == ST_IDLE) && start;
  assign launch     = start_ok && (len_sat != '0);
  assign capture    = (state == ST_DRAIN) && s_axis_product_tvalid;
  assign wd_expired = (wd_cnt == WD_BITS'(TIMEOUT - 1));

  assign busy                  = (state != ST_IDLE);
  assign m_axis_product_tready = (state == ST_DRAIN);
  assign x_rd_en               = ag_rd_en;
  assign y_rd_en               = ag_rd_en;
  assign m_axis_x_tvalid       = ag_beat_vld;
  assign m_axis_y_tvalid       = ag_beat_vld;

  dot_prod_seq_addr_gen #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .launch   (launch),
    .len      (len_sat),
    .shift    (cfg_shift),
    .rd_en    (ag_rd_en),
    .x_addr   (x_rd_addr),
    .y_addr   (y_rd_addr),
    .last_rd  (ag_last),
    .dat_vld  (ag_dat_vld),
    .beat_vld (ag_beat_vld)
  );

  // Run control: state transitions, done pulse, sticky timeout flag, latched lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      shift_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            err_timeout <= 1'b0;
            shift_q     <= cfg_shift;
            if (len_sat == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (ag_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (capture) begin
            state <= ST_RESULT;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_RESULT: begin
          if (res_valid && res_ready) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Watchdog: counts cycles spent waiting in DRAIN, idles at zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != ST_DRAIN) begin
      wd_cnt <= '0;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt + WD_BITS'(1);
    end
  end

  // Beat register: buffer read data lands here one cycle after it is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xi <= '0;
      xq <= '0;
      yi <= '0;
      yq <= '0;
    end else if (ag_dat_vld) begin
      xi <= x_rd_i;
      xq <= x_rd_q;
      yi <= y_rd_i;
      yq <= y_rd_q;
    end
  end

  // Result register: captured in DRAIN, held stable until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_i     <= '0;
      res_q     <= '0;
      res_shift <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_i     <= i;
      res_q     <= q;
      res_shift <= shift_q;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
